// File: rtl/asmd_mult_sequencer.sv
// -----------------------------------------------------------------------------
// asmd_mult_sequencer
//
// Purpose:
//   Feeds operand pairs to an asmd_multiplier and accumulates the products.
//   When the pair tagged "last" completes, it presents the dot-product result.
//   Each accepted pair produces exactly one mult_start pulse. After that pulse
//   the sequencer waits for the multiplier's ready line to drop and then rise
//   again. The product is added into a running sum. The result is held until
//   the consumer acknowledges it.
//
// Ports:
//   clk, reset      : system clock (rising edge) and synchronous active-high reset,
//                     shared with the multiplier.
//   in_valid/in_ready, in_a, in_b, in_last
//                   : operand pair stream (valid/ready handshake).
//   mult_start      : one-cycle start pulse to the multiplier.
//   mult_word0/1    : latched operands, stable until the next accept.
//   mult_ready      : multiplier idle/ready.
//   mult_product    : multiplier product, sampled when ready returns high.
//   sum_valid, sum, sum_count, overflow
//                   : result of a vector, held stable until sum_ack.
//   sum_ack         : consumer takes the result (only honoured while presenting).
// -----------------------------------------------------------------------------
module asmd_mult_sequencer #(
    parameter int word_length = 4,
    parameter int acc_width   = 12,
    parameter int count_width = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [word_length-1:0]     in_a,
    input  logic [word_length-1:0]     in_b,
    input  logic                       in_last,
    output logic                       mult_start,
    output logic [word_length-1:0]     mult_word0,
    output logic [word_length-1:0]     mult_word1,
    input  logic                       mult_ready,
    input  logic [2*word_length-1:0]   mult_product,
    output logic                       sum_valid,
    output logic [acc_width-1:0]       sum,
    output logic [count_width-1:0]     sum_count,
    output logic                       overflow,
    input  logic                       sum_ack
);

    localparam int ACC_EXT_W = acc_width + 1;
    localparam int CNT_EXT_W = count_width + 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [word_length-1:0]   word0_q, word0_d;
    logic [word_length-1:0]   word1_q, word1_d;
    logic                     last_q,  last_d;
    logic                     start_q, start_d;
    logic                     valid_q, valid_d;
    logic                     ovf_q,   ovf_d;
    logic [acc_width-1:0]     acc_q,   acc_d;
    logic [count_width-1:0]   count_q, count_d;

    logic [ACC_EXT_W-1:0]     acc_sum;
    logic [CNT_EXT_W-1:0]     count_inc;
    logic                     accept;

    // Returns {carry, acc + zero-extended product}. The carry bit marks a wrap
    // out of the accumulator width.
    function automatic logic [ACC_EXT_W-1:0] acc_add(
        input logic [acc_width-1:0]     a,
        input logic [2*word_length-1:0] p
    );
        return {1'b0, a} + ACC_EXT_W'(p);
    endfunction

    // Returns {saturated, next_count}. The counter sticks at all-ones, and an
    // increment attempted at that value is reported as saturation.
    function automatic logic [CNT_EXT_W-1:0] count_sat_inc(
        input logic [count_width-1:0] c
    );
        if (&c) begin
            return {1'b1, c};
        end
        return {1'b0, c + count_width'(1)};
    endfunction

    assign acc_sum   = acc_add(acc_q, mult_product);
    assign count_inc = count_sat_inc(count_q);

    // The ready decode depends only on the registered state plus the
    // multiplier's ready line. It is forced low while reset is held.
    assign in_ready = (state_q == IDLE) && mult_ready && !reset;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        word0_d = word0_q;
        word1_d = word1_q;
        last_d  = last_q;
        start_d = 1'b0;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        acc_d   = acc_q;
        count_d = count_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    word0_d = in_a;
                    word1_d = in_b;
                    last_d  = in_last;
                    start_d = 1'b1;
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                state_d = WAIT_BUSY;
            end

            // The multiplier may keep ready high for a few cycles after start.
            // Wait for it to go busy before looking for completion.
            WAIT_BUSY: begin
                if (!mult_ready) begin
                    state_d = WAIT_DONE;
                end
            end

            WAIT_DONE: begin
                if (mult_ready) begin
                    acc_d   = acc_sum[acc_width-1:0];
                    count_d = count_inc[count_width-1:0];
                    ovf_d   = ovf_q | acc_sum[acc_width] | count_inc[count_width];
                    if (last_q) begin
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            DONE: begin
                if (sum_ack) begin
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            word0_q <= '0;
            word1_q <= '0;
            last_q  <= 1'b0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            word0_q <= word0_d;
            word1_q <= word1_d;
            last_q  <= last_d;
            start_q <= start_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

    assign mult_start = start_q;
    assign mult_word0 = word0_q;
    assign mult_word1 = word1_q;
    assign sum_valid  = valid_q;
    assign sum        = acc_q;
    assign sum_count  = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_asmd_mult_sequencer.sv
// -----------------------------------------------------------------------------
// tb_asmd_mult_sequencer
//
// Purpose:
//   Testbench for asmd_mult_sequencer, built with an 8-bit accumulator so that
//   wrap-around can be provoked. A small behavioural multiplier answers the
//   start pulses. After a start, its ready line stays high for one more cycle,
//   then goes low for several cycles. While busy it drives a junk product.
//   Vectors come from a table. Expected results are queued when a vector is
//   driven and are compared when sum_valid appears.
// -----------------------------------------------------------------------------
module tb_asmd_mult_sequencer;

    localparam int WL    = 4;
    localparam int ACC_W = 8;
    localparam int CW    = 4;
    localparam int LAT   = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [WL-1:0]   in_a = '0;
    logic [WL-1:0]   in_b = '0;
    logic            in_last = 1'b0;
    logic            mult_start;
    logic [WL-1:0]   mult_word0;
    logic [WL-1:0]   mult_word1;
    logic            mult_ready = 1'b1;
    logic [2*WL-1:0] mult_product = '0;
    logic            sum_valid;
    logic [ACC_W-1:0] sum;
    logic [CW-1:0]   sum_count;
    logic            overflow;
    logic            sum_ack = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;
    int start_pulses = 0;

    always #5 clk = ~clk;

    asmd_mult_sequencer #(
        .word_length(WL),
        .acc_width  (ACC_W),
        .count_width(CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_last     (in_last),
        .mult_start  (mult_start),
        .mult_word0  (mult_word0),
        .mult_word1  (mult_word1),
        .mult_ready  (mult_ready),
        .mult_product(mult_product),
        .sum_valid   (sum_valid),
        .sum         (sum),
        .sum_count   (sum_count),
        .overflow    (overflow),
        .sum_ack     (sum_ack)
    );

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural multiplier ----------------
    logic [WL-1:0] m_a = '0;
    logic [WL-1:0] m_b = '0;
    int            mcnt = 0;

    always @(posedge clk) begin
        if (reset) begin
            mult_ready   <= 1'b1;
            mult_product <= '0;
            mcnt         <= 0;
        end else if (mcnt == 0) begin
            if (mult_start) begin
                m_a  <= mult_word0;
                m_b  <= mult_word1;
                mcnt <= 1;
            end
        end else if (mcnt == 1) begin
            mult_ready   <= 1'b0;
            mult_product <= 8'hAA;
            mcnt         <= 2;
        end else if (mcnt < 1 + LAT) begin
            mcnt <= mcnt + 1;
        end else begin
            mult_ready   <= 1'b1;
            mult_product <= m_a * m_b;
            mcnt         <= 0;
        end
    end

    // Start pulses are counted, and the operands must not move while the
    // multiplier is working on them.
    always @(negedge clk) begin
        if (!reset) begin
            if (mult_start) start_pulses++;
            if (mcnt != 0) begin
                check("word0_stable", int'(mult_word0), int'(m_a));
                check("word1_stable", int'(mult_word1), int'(m_b));
            end
        end
    end

    // ---------------- vector table and scoreboard ----------------
    typedef struct {
        int                 n;
        logic [3:0][WL-1:0] a;
        logic [3:0][WL-1:0] b;
        int                 exp_sum;
        int                 exp_cnt;
        int                 exp_ovf;
        bit                 hold;
    } vec_t;

    typedef struct {
        int sum;
        int cnt;
        int ovf;
        int starts;
    } exp_t;

    vec_t vecs[5];
    exp_t exp_q[$];

    // Called at a negedge. Returns at the negedge after the accepting edge.
    task automatic send_pair(input logic [WL-1:0] a, input logic [WL-1:0] b,
                             input logic last);
        int t;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("accept_timeout", int'(t < 200), 1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(input int v);
        exp_t e;
        int   s0;
        int   t;
        s0       = start_pulses;
        e.sum    = vecs[v].exp_sum;
        e.cnt    = vecs[v].exp_cnt;
        e.ovf    = vecs[v].exp_ovf;
        e.starts = vecs[v].n;
        exp_q.push_back(e);
        // An ack while the vector is still in progress must be ignored.
        sum_ack = (v == 1);
        for (int i = 0; i < vecs[v].n; i++) begin
            send_pair(vecs[v].a[i], vecs[v].b[i], (i == vecs[v].n - 1));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        sum_ack  = 1'b0;
        t = 0;
        while (!sum_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("sum_valid_timeout", int'(t < 200), 1);
        e = exp_q.pop_front();
        check("sum", int'(sum), e.sum);
        check("sum_count", int'(sum_count), e.cnt);
        check("overflow", int'(overflow), e.ovf);
        check("start_pulses", start_pulses - s0, e.starts);
        check("in_ready_done", int'(in_ready), 0);
        if (vecs[v].hold) begin
            s0 = start_pulses;
            repeat (20) begin
                @(negedge clk);
                check("hold_valid", int'(sum_valid), 1);
                check("hold_sum", int'(sum), e.sum);
                check("hold_count", int'(sum_count), e.cnt);
                check("hold_in_ready", int'(in_ready), 0);
            end
            check("hold_no_start", start_pulses - s0, 0);
        end
        sum_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sum_ack = 1'b0;
        check("ack_valid", int'(sum_valid), 0);
        check("ack_sum", int'(sum), 0);
        check("ack_count", int'(sum_count), 0);
        check("ack_overflow", int'(overflow), 0);
        check("ack_in_ready", int'(in_ready), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 0);
        check({tag, "_start"}, int'(mult_start), 0);
        check({tag, "_word0"}, int'(mult_word0), 0);
        check({tag, "_word1"}, int'(mult_word1), 0);
        check({tag, "_sum_valid"}, int'(sum_valid), 0);
        check({tag, "_sum"}, int'(sum), 0);
        check({tag, "_count"}, int'(sum_count), 0);
        check({tag, "_overflow"}, int'(overflow), 0);
    endtask

    initial begin
        int t;
        // single pair: 4*5
        vecs[0].n = 1; vecs[0].a = {4'd0, 4'd0, 4'd0, 4'd4};
        vecs[0].b = {4'd0, 4'd0, 4'd0, 4'd5};
        vecs[0].exp_sum = 20; vecs[0].exp_cnt = 1; vecs[0].exp_ovf = 0; vecs[0].hold = 0;
        // 225 + 21 + 0 (zero product still counted)
        vecs[1].n = 3; vecs[1].a = {4'd0, 4'd0, 4'd3, 4'd15};
        vecs[1].b = {4'd0, 4'd9, 4'd7, 4'd15};
        vecs[1].exp_sum = 246; vecs[1].exp_cnt = 3; vecs[1].exp_ovf = 0; vecs[1].hold = 0;
        // 450 mod 256 with carry out
        vecs[2].n = 2; vecs[2].a = {4'd0, 4'd0, 4'd15, 4'd15};
        vecs[2].b = {4'd0, 4'd0, 4'd15, 4'd15};
        vecs[2].exp_sum = 194; vecs[2].exp_cnt = 2; vecs[2].exp_ovf = 1; vecs[2].hold = 0;
        // four back-to-back pairs: 2 + 12 + 30 + 7, result held 20 cycles
        vecs[3].n = 4; vecs[3].a = {4'd7, 4'd5, 4'd3, 4'd1};
        vecs[3].b = {4'd1, 4'd6, 4'd4, 4'd2};
        vecs[3].exp_sum = 51; vecs[3].exp_cnt = 4; vecs[3].exp_ovf = 0; vecs[3].hold = 1;
        // after mid-operation reset: 2*3
        vecs[4].n = 1; vecs[4].a = {4'd0, 4'd0, 4'd0, 4'd2};
        vecs[4].b = {4'd0, 4'd0, 4'd0, 4'd3};
        vecs[4].exp_sum = 6; vecs[4].exp_cnt = 1; vecs[4].exp_ovf = 0; vecs[4].hold = 0;

        reset = 1'b1;
        repeat (10) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check("idle_in_ready", int'(in_ready), 1);

        for (int v = 0; v < 4; v++) begin
            run_vec(v);
        end

        // Reset while the second pair of a vector is being multiplied.
        send_pair(4'd1, 4'd1, 1'b0);
        send_pair(4'd2, 4'd2, 1'b0);
        in_valid = 1'b0;
        t = 0;
        while (mult_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("busy_timeout", int'(t < 50), 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b0;
        @(negedge clk);
        run_vec(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/asmd_mult_sequencer.md
Name: asmd_mult_sequencer

Overview:
Upstream operand feeder and downstream result accumulator for asmd_multiplier.
- Accepts a stream of operand pairs over a valid/ready handshake.
- Issues one start pulse per pair to the multiplier and waits for the ready low→high completion sequence.
- Accumulates products into a running sum and presents the dot-product result when the pair tagged "last" completes.
- Sits between the operand source and asmd_multiplier, and shares its clk/reset.

Parameters:
- word_length, 4, operand width; must match asmd_multiplier word_length.
- acc_width, 12, accumulator/sum width; must be ≥ 2*word_length.
- count_width, 4, width of the pair counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept a pair this cycle.
- in_a  in  word_length  operand A.
- in_b  in  word_length  operand B.
- in_last  in  1  pair is final element of vector.
- mult_start  out  1  one-cycle start pulse to multiplier.
- mult_word0  out  word_length  operand to multiplier word0.
- mult_word1  out  word_length  operand to multiplier word1.
- mult_ready  in  1  multiplier ready/idle.
- mult_product  in  2*word_length  multiplier product.
- sum_valid  out  1  result available.
- sum  out  acc_width  accumulated sum.
- sum_count  out  count_width  number of pairs accumulated.
- overflow  out  1  sticky; accumulator or counter wrapped/saturated.
- sum_ack  in  1  consumer takes result.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. On reset, every output goes to 0 and the state goes to IDLE. This includes in_ready=0 during the reset cycle and mult_word0/1=0.
- Reset takes priority over all other inputs, in any state. Reset mid-operation discards the partial sum and count; the multiplier is reset by the same signal.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE.
- IDLE:
  - in_ready = mult_ready (registered state decode; combinational use of mult_ready is permitted).
  - On in_valid & in_ready at edge T: latch in_a→mult_word0, in_b→mult_word1, in_last→last_r; go to ISSUE.
- ISSUE: mult_start=1 for exactly the one cycle after T; next state WAIT_BUSY. mult_start is 0 in all other states.
- WAIT_BUSY: stay until mult_ready==0, then go to WAIT_DONE. Required because ready may stay high for one or more cycles after start.
- WAIT_DONE:
  - Stay until mult_ready==1.
  - On that edge: acc ← acc + zero-extend(mult_product), truncated to acc_width; overflow set if a carry out of acc_width occurs.
  - On the same edge: count ← count+1, saturating at 2^count_width−1; overflow set on saturation.
  - Next state is DONE if last_r, else IDLE.
- DONE:
  - sum_valid=1; sum, sum_count and overflow are held stable; in_ready=0.
  - On sum_ack: clear acc, count and overflow; sum_valid←0; go to IDLE. The next pair is accepted no earlier than the following cycle.
- sum_ack outside DONE: ignored.
- in_valid outside IDLE: ignored; no pair is lost or duplicated. The source holds the pair until the in_ready handshake.
- mult_word0/1 hold the latched operands until the next accept; they are stable throughout the multiplication.
- Throughput: one pair per multiplier latency + 3 cycles minimum.
- Zero product: accumulated normally; count still increments.

Test Plan:
- Single pair: reset 10 cycles; in_a=4, in_b=5, in_last=1 → exactly one mult_start pulse; then sum_valid=1, sum=20, sum_count=1, overflow=0. Assert sum_ack → sum_valid=0, sum=0.
- Vector of three pairs (15,15),(3,7),(0,9), last on the third → sum=246, sum_count=3, overflow=0; exactly three start pulses, one per pair.
- Overflow with acc_width=8: pairs (15,15),(15,15), last on the second → sum=194 (450 mod 256), overflow=1, sum_count=2; ack clears overflow to 0.
- Back-pressure: in_valid held high continuously with 4 distinct pairs → in_ready low from ISSUE through WAIT_DONE; each pair accepted once; mult_word0/1 stable while mult_ready=0.
- Result hold: withhold sum_ack 20 cycles after sum_valid → sum/sum_count constant, in_ready=0, no mult_start; ack then allows the next vector.
- Reset mid-operation: assert reset for 1 cycle during WAIT_DONE of the second pair → all outputs 0 next cycle. A new vector (2,3) with last → sum=6, sum_count=1.
